// File: rtl/chain_mixer_dispense_seq.sv
// rtl/chain_mixer_dispense_seq.sv - valve sequencer for the serial mixer chain
//
// Opens the carrier inlet, meters each enabled reagent inlet in stage order
// with a closed-valve mixing dwell after every dose, then presents the
// finished plug downstream on a valid/ready handshake.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, abort          begin sequence (IDLE only) / cancel active sequence
//   carrier_ticks         cycles valve_j0 stays open (0 treated as 1)
//   reagent_ticks         cycles each valve_k[i] stays open (0 treated as 1)
//   dwell_ticks           closed-valve cycles after each dose (0 treated as 1)
//   stage_mask            1 = dose stage i, 0 = skip stage i
//   valve_j0, valve_k     carrier valve, reagent valves (one-hot or zero)
//   stage_idx             current stage
//   busy                  high in any state other than IDLE
//   out_valid, out_ready  plug handoff to the collector
//   done, err_abort       one-cycle completion / abort pulses
module chain_mixer_dispense_seq #(
    parameter int N_STAGES = 64,
    parameter int CNT_W    = 16,
    parameter int IDX_W    = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [CNT_W-1:0]    carrier_ticks,
    input  logic [CNT_W-1:0]    reagent_ticks,
    input  logic [CNT_W-1:0]    dwell_ticks,
    input  logic [N_STAGES-1:0] stage_mask,
    output logic                valve_j0,
    output logic [N_STAGES-1:0] valve_k,
    output logic [IDX_W-1:0]    stage_idx,
    output logic                busy,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                done,
    output logic                err_abort
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CARRIER,
        S_REAGENT,
        S_DWELL,
        S_SKIP,
        S_OUTPUT
    } state_t;

    localparam logic [N_STAGES-1:0] K_ONE     = N_STAGES'(1);
    localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(N_STAGES - 1);

    state_t                state_q, state_n;
    logic [CNT_W-1:0]      cnt_q, cnt_n;
    logic [IDX_W-1:0]      idx_n;
    logic [CNT_W-1:0]      reagent_m1_q, dwell_m1_q;
    logic [N_STAGES-1:0]   mask_q;
    logic                  done_n, err_n;
    logic [IDX_W-1:0]      idx_inc;
    logic                  expired;
    logic                  accept_start;

    // Counters hold "remaining cycles minus one", so max(ticks,1)-1 is the load value.
    function automatic logic [CNT_W-1:0] ticks_m1(input logic [CNT_W-1:0] t);
        return (t == '0) ? '0 : t - CNT_W'(1);
    endfunction

    assign idx_inc      = stage_idx + IDX_W'(1);
    assign expired      = (cnt_q == '0);
    assign accept_start = (state_q == S_IDLE) && start && !abort;

    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        idx_n   = stage_idx;
        done_n  = 1'b0;
        err_n   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept_start) begin
                    state_n = S_CARRIER;
                    cnt_n   = ticks_m1(carrier_ticks);
                    idx_n   = '0;
                end
            end
            S_CARRIER: begin
                if (expired) begin
                    // Carrier hands straight to stage 0 without a closed gap.
                    state_n = mask_q[0] ? S_REAGENT : S_SKIP;
                    cnt_n   = mask_q[0] ? reagent_m1_q : '0;
                end else begin
                    cnt_n = cnt_q - CNT_W'(1);
                end
            end
            S_REAGENT: begin
                if (expired) begin
                    state_n = S_DWELL;
                    cnt_n   = dwell_m1_q;
                end else begin
                    cnt_n = cnt_q - CNT_W'(1);
                end
            end
            S_DWELL, S_SKIP: begin
                if (expired) begin
                    if (stage_idx == LAST_IDX) begin
                        state_n = S_OUTPUT;
                    end else begin
                        idx_n   = idx_inc;
                        state_n = mask_q[idx_inc] ? S_REAGENT : S_SKIP;
                        cnt_n   = mask_q[idx_inc] ? reagent_m1_q : '0;
                    end
                end else begin
                    cnt_n = cnt_q - CNT_W'(1);
                end
            end
            S_OUTPUT: begin
                if (out_ready) begin
                    state_n = S_IDLE;
                    done_n  = 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        // Abort overrides expiry and the output handshake alike.
        if ((state_q != S_IDLE) && abort) begin
            state_n = S_IDLE;
            cnt_n   = '0;
            done_n  = 1'b0;
            err_n   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            stage_idx    <= '0;
            reagent_m1_q <= '0;
            dwell_m1_q   <= '0;
            mask_q       <= '0;
            valve_j0     <= 1'b0;
            valve_k      <= '0;
            busy         <= 1'b0;
            out_valid    <= 1'b0;
            done         <= 1'b0;
            err_abort    <= 1'b0;
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            stage_idx <= idx_n;
            if (accept_start) begin
                reagent_m1_q <= ticks_m1(reagent_ticks);
                dwell_m1_q   <= ticks_m1(dwell_ticks);
                mask_q       <= stage_mask;
            end
            // Outputs are decoded from the next state so they change on the entry edge.
            valve_j0  <= (state_n == S_CARRIER);
            valve_k   <= (state_n == S_REAGENT) ? (K_ONE << idx_n) : '0;
            busy      <= (state_n != S_IDLE);
            out_valid <= (state_n == S_OUTPUT);
            done      <= done_n;
            err_abort <= err_n;
        end
    end

endmodule

// File: tb/tb_chain_mixer_dispense_seq.sv
// tb/tb_chain_mixer_dispense_seq.sv - self-checking bench for chain_mixer_dispense_seq
module tb_chain_mixer_dispense_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, abort = 1'b0, out_ready = 1'b0;
    logic [15:0] carrier_ticks = '0, reagent_ticks = '0, dwell_ticks = '0;
    logic [3:0]  stage_mask = '0;
    logic        valve_j0, busy, out_valid, done, err_abort;
    logic [3:0]  valve_k;
    logic [1:0]  stage_idx;

    logic        b_start = 1'b0, b_abort = 1'b0, b_out_ready = 1'b1;
    logic [15:0] b_c = '0, b_r = '0, b_d = '0;
    logic [63:0] b_mask = '0;
    logic        b_valve_j0, b_busy, b_out_valid, b_done, b_err_abort;
    logic [63:0] b_valve_k;
    logic [5:0]  b_stage_idx;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    chain_mixer_dispense_seq #(.N_STAGES(4), .CNT_W(16), .IDX_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .carrier_ticks(carrier_ticks), .reagent_ticks(reagent_ticks),
        .dwell_ticks(dwell_ticks), .stage_mask(stage_mask),
        .valve_j0(valve_j0), .valve_k(valve_k), .stage_idx(stage_idx),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
        .done(done), .err_abort(err_abort)
    );

    chain_mixer_dispense_seq #(.N_STAGES(64), .CNT_W(16), .IDX_W(6)) big (
        .clk(clk), .rst_n(rst_n), .start(b_start), .abort(b_abort),
        .carrier_ticks(b_c), .reagent_ticks(b_r),
        .dwell_ticks(b_d), .stage_mask(b_mask),
        .valve_j0(b_valve_j0), .valve_k(b_valve_k), .stage_idx(b_stage_idx),
        .busy(b_busy), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .done(b_done), .err_abort(b_err_abort)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: on start, expand the whole dispense into a per-cycle list of valve
    // settings; then replay it, hold the plug until accepted, honour abort.
    typedef struct packed {
        logic       j0;
        logic [3:0] k;
        logic [1:0] idx;
    } ent_t;

    ent_t q[$];
    ent_t cur;
    int   phase;      // 0 idle, 1 dispensing, 2 waiting for collector
    logic e_done, e_err;

    function automatic int clampv(input logic [15:0] t);
        return (t == 16'd0) ? 1 : int'(t);
    endfunction

    task automatic build_plan();
        int c, r, d;
        c = clampv(carrier_ticks);
        r = clampv(reagent_ticks);
        d = clampv(dwell_ticks);
        q.delete();
        for (int j = 0; j < c; j++) q.push_back('{1'b1, 4'b0, 2'd0});
        for (int s = 0; s < 4; s++) begin
            if (stage_mask[s]) begin
                for (int j = 0; j < r; j++) q.push_back('{1'b0, 4'(1 << s), 2'(s)});
                for (int j = 0; j < d; j++) q.push_back('{1'b0, 4'b0, 2'(s)});
            end else begin
                q.push_back('{1'b0, 4'b0, 2'(s)});
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            phase  = 0;
            cur    = '0;
            e_done = 1'b0;
            e_err  = 1'b0;
        end else begin
            e_done = 1'b0;
            e_err  = 1'b0;
            if (phase != 0 && abort) begin
                phase = 0;
                q.delete();
                e_err = 1'b1;
            end else begin
                case (phase)
                    0: if (start && !abort) begin
                        build_plan();
                        cur   = q.pop_front();
                        phase = 1;
                    end
                    1: if (q.size() > 0) cur = q.pop_front();
                       else phase = 2;
                    default: if (out_ready) begin
                        phase  = 0;
                        e_done = 1'b1;
                    end
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("valve_j0", valve_j0, (phase == 1) ? cur.j0 : 1'b0);
            chk("valve_k", valve_k, (phase == 1) ? cur.k : 4'b0);
            chk("out_valid", out_valid, phase == 2);
            chk("busy", busy, phase != 0);
            chk("done", done, e_done);
            chk("err_abort", err_abort, e_err);
            if (phase != 0) chk("stage_idx", stage_idx, cur.idx);
            chk("excl_valves", valve_j0 && (valve_k != 0), 1'b0);
            chk("big_onehot0", $onehot0(b_valve_k), 1'b1);
            chk("big_excl", b_valve_j0 && (b_valve_k != 0), 1'b0);
        end
    end

    task automatic run_seq(input logic [15:0] c, r, d, input logic [3:0] m,
                           input int hold, input int exp_ov);
        int n;
        carrier_ticks = c; reagent_ticks = r; dwell_ticks = d; stage_mask = m;
        out_ready = (hold == 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // Scramble inputs: the running sequence must use the latched config.
        carrier_ticks = 16'($urandom); reagent_ticks = 16'($urandom);
        dwell_ticks = 16'($urandom); stage_mask = 4'($urandom);
        n = 1;
        while (!out_valid && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("ov_cycle", 64'(n), 64'(exp_ov));
        for (int i = 0; i < hold; i++) begin
            start = (i % 2 == 0);
            @(negedge clk);
            chk("ov_held", {out_valid, valve_j0, valve_k}, 6'b100000);
        end
        start = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("done_pulse", {done, out_valid, busy}, 3'b100);
        @(negedge clk);
        chk("done_clear", done, 1'b0);
    endtask

    initial begin
        int n, exp_big;
        repeat (3) @(negedge clk);
        chk("rst_outputs", {valve_j0, valve_k, stage_idx, busy, out_valid, done, err_abort}, '0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("idle_after_rst", {valve_j0, valve_k, busy, out_valid}, '0);

        // abort together with start in IDLE: no effect
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("idle_abort_start", {busy, err_abort, valve_j0}, 3'b000);

        run_seq(16'd3, 16'd2, 16'd1, 4'b1111, 0, 16);
        run_seq(16'd1, 16'd1, 16'd1, 4'b0101, 0, 8);
        run_seq(16'd0, 16'd0, 16'd0, 4'b0000, 0, 6);

        // abort while k[1] is open
        carrier_ticks = 16'd1; reagent_ticks = 16'd3; dwell_ticks = 16'd1; stage_mask = 4'b1111;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!valve_k[1] && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("k1_reached", valve_k[1], 1'b1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_state", {valve_j0, valve_k, out_valid, busy, done, err_abort}, 9'b000000001);
        @(negedge clk);
        chk("abort_pulse_end", err_abort, 1'b0);
        run_seq(16'd1, 16'd1, 16'd1, 4'b0101, 0, 8);

        // collector stalls 10 cycles; start pulses during OUTPUT ignored
        run_seq(16'd2, 16'd1, 16'd0, 4'b1010, 10, 9);

        // reset in the middle of a dose
        carrier_ticks = 16'd1; reagent_ticks = 16'd5; dwell_ticks = 16'd1; stage_mask = 4'b1111;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (valve_k == 4'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reagent_open", valve_k, 4'b0001);
        #2 rst_n = 1'b0;
        #1 chk("async_close", {valve_j0, valve_k, busy}, '0);
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst", {valve_j0, valve_k, stage_idx, busy, out_valid, done, err_abort}, '0);

        // 64-stage randomized run
        b_c = 16'($urandom_range(0, 3));
        b_r = 16'($urandom_range(0, 3));
        b_d = 16'($urandom_range(0, 3));
        b_mask = {$urandom, $urandom};
        exp_big = clampv(b_c);
        for (int s = 0; s < 64; s++)
            exp_big += b_mask[s] ? (clampv(b_r) + clampv(b_d)) : 1;
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        n = 1;
        while (!b_out_valid && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("big_ov_cycle", 64'(n), 64'(exp_big + 1));
        @(negedge clk);
        chk("big_done", {b_done, b_out_valid, b_busy}, 3'b100);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
